// File: rtl/cpu_pkg.sv
// Shared multiply-unit state type, latency and writeback-select encodings.
// MUL_HILO_FAST_EN selects the single-stage multiply latency.
package cpu_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

`ifdef MUL_HILO_FAST_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = MUL_WIDTH + 1;
`endif

  // MFCOP_SEL encodings used by the decoder and the writeback mux
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;
  localparam logic [1:0] SEL_C0  = 2'b11;

endpackage

// File: rtl/mul_hilo_unit_mul_shift_add.sv
// Unsigned magnitude multiply datapath: shift-add accumulator plus iteration counter.
// With MUL_HILO_FAST_EN the loop collapses to one registered native multiply.
module mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   acc_o
);

`ifdef MUL_HILO_FAST_EN
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
    end else if (step_i) begin
      acc_q <= {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q};
    end
  end

  assign last_o = 1'b1;
  assign acc_o  = acc_q;
`else
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;

  // Multiplier rides in the low half and is consumed as the product shifts in
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) sum = sum + {1'b0, mcand_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= mcand_i;
      acc_q   <= {{WIDTH{1'b0}}, mplier_i};
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q <= {sum, acc_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_o  = acc_q;
`endif

endmodule

// File: rtl/mul_hilo_unit.sv
// Execute-stage multiply unit: sign handling, sequencing FSM and HI/LO registers.
// Define MUL_HILO_FAST_EN for the single-stage (DSP) multiply.
module mul_hilo_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  input  logic             hilo_rd_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mul_state_t         state_q, state_d;
  logic               neg_q, neg_d;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               load, step, wr, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, product;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign mag_a   = (signed_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
  assign mag_b   = (signed_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
  assign product = neg_q ? -acc : acc;

  mul_shift_add #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (load),
    .step_i   (step),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .last_o   (last),
    .acc_o    (acc)
  );

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    if (kill_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      load    = 1'b1;
      neg_d   = signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
      state_d = CALC;
    end else begin
      unique case (state_q)
        CALC: begin
          step = 1'b1;
          if (last) state_d = FIX;
        end
        FIX: begin
          wr      = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      done_q  <= wr;
      if (wr) {hi_q, lo_q} <= product;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = hilo_rd_i & busy_o;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Scoreboard bench for mul_hilo_unit in the default (iterative) build.
module tb_mul_hilo_unit;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        kill_i = 1'b0;
  logic        hilo_rd_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_hilo = '0;

  always #5 clk_i = ~clk_i;

  mul_hilo_unit dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .kill_i    (kill_i),
    .hilo_rd_i (hilo_rd_i),
    .busy_o    (busy_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Every DONE pulse must retire exactly one queued product
  always @(negedge clk_i) begin
    if (rst_n_i && done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'(done_o), 64'd0);
      else chk("product", {hi_o, lo_o}, exp_q.pop_front());
    end
  end

  // Called at a negedge: START is driven in the current cycle (cycle 0)
  task automatic run_mul(input logic s, input logic [31:0] a, input logic [31:0] b, input logic hrd);
    logic [63:0] p;
    p = model(s, a, b);
    signed_i = s; op_a_i = a; op_b_i = b; start_i = 1'b1; hilo_rd_i = hrd;
    exp_q.push_back(p);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 1; c <= MUL_LAT; c++) begin
      #1;
      chk("busy", 64'(busy_o), 64'd1);
      chk("no_early_done", 64'(done_o), 64'd0);
      chk("hold", {hi_o, lo_o}, exp_hilo);
      if (hrd) chk("stall", 64'(stall_o), 64'd1);
      @(negedge clk_i);
    end
    #1;
    exp_hilo = p;
    chk("busy_at_done", 64'(busy_o), 64'd0);
    chk("done", 64'(done_o), 64'd1);
    if (hrd) begin
      chk("stall_at_done", 64'(stall_o), 64'd0);
      chk("lo_at_done", 64'(lo_o), 64'(p[31:0]));
    end
    @(negedge clk_i);
    hilo_rd_i = 1'b0;
    chk("done_pulse", 64'(done_o), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    repeat (2) @(negedge clk_i);
    hilo_rd_i = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    hilo_rd_i = 1'b0;
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_max", exp_hilo, 64'hFFFFFFFE_00000001);
    run_mul(1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b0);
    chk("mult_neg", exp_hilo, 64'hFFFFFFFF_FFFFFFF1);
    run_mul(1'b1, 32'h80000000, 32'h80000000, 1'b1);
    chk("mult_min", exp_hilo, 64'h40000000_00000000);

    // Preload HI/LO = 0x11111111/0x22222222, then kill 7*9 in cycle 10
    run_mul(1'b0, 32'h22222222, 32'h80000001, 1'b0);
    signed_i = 1'b0; op_a_i = 32'd7; op_b_i = 32'd9; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("kill_busy", 64'(busy_o), 64'd0);
      chk("kill_hilo", {hi_o, lo_o}, 64'h11111111_22222222);
      @(negedge clk_i);
    end

    // Restart: 2*3 then 4*5 started in cycle 5; only 20 may appear
    signed_i = 1'b0; op_a_i = 32'd2; op_b_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) begin
      #1 chk("restart_busy", 64'(busy_o), 64'd1);
      @(negedge clk_i);
    end
    run_mul(1'b0, 32'd4, 32'd5, 1'b0);
    chk("restart_result", exp_hilo, 64'd20);

    // KILL with START in the same cycle: nothing starts
    signed_i = 1'b1; op_a_i = 32'd11; op_b_i = 32'd13; start_i = 1'b1; kill_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; kill_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1 chk("killstart_busy", 64'(busy_o), 64'd0);
      @(negedge clk_i);
    end

    // Reset in cycle 12 of an active multiply
    signed_i = 1'b0; op_a_i = 32'd123; op_b_i = 32'd456; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (11) @(negedge clk_i);
    rst_n_i = 1'b0; hilo_rd_i = 1'b1;
    @(negedge clk_i);
    #1;
    exp_hilo = '0;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    rst_n_i = 1'b1; hilo_rd_i = 1'b0;
    @(negedge clk_i);
    run_mul(1'b1, 32'h00000007, 32'hFFFFFFF9, 1'b1);
    chk("post_rst", exp_hilo, 64'hFFFFFFFF_FFFFFFCF);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_mul(rs, ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
